fifo_umbral: RTL and testbench

//   Synchronous FIFO with programmable almost-full/almost-empty thresholds (umbrales).
//   One instance per main-FIFO, VC-FIFO and destination-FIFO slot.

---
 rtl/fifo_umbral.sv | 115 +++++++++++
 tb/tb_fifo_umbral.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_umbral.sv
// fifo_umbral: synchronous FIFO with programmable almost-full / almost-empty
// thresholds (umbrales) and a sticky overflow/underflow error flag.
// Ports:
//   clk, reset                      clock, async active-high reset
//   push, data_in                   write request and data
//   pop, data_out, valid_out        read request, registered read data, read strobe
//   umbral_load, umbral_alto/bajo   threshold load strobe and values (clamped to DEPTH)
//   count                           occupancy 0..DEPTH
//   fifo_empty, fifo_full           occupancy flags
//   almost_full, almost_empty       threshold flags
//   fifo_error                      sticky overflow/underflow flag
module fifo_umbral #(
  parameter int unsigned DATA_W = 6,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  input  logic              umbral_load,
  input  logic [ADDR_W:0]   umbral_alto,
  input  logic [ADDR_W:0]   umbral_bajo,
  output logic [ADDR_W:0]   count,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              fifo_error
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CW    = ADDR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [DATA_W-1:0] r_data_out;
  logic              r_valid;
  logic              r_error;
  logic [CW-1:0]     r_alto;
  logic [CW-1:0]     r_bajo;

  logic              w_empty;
  logic              w_full;
  logic              w_pop_ok;
  logic              w_push_ok;
  logic [CW-1:0]     w_alto_clamped;
  logic [CW-1:0]     w_bajo_clamped;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_pop_ok  = pop & ~w_empty;
  // A full FIFO still accepts a push when a pop frees a slot on the same edge.
  assign w_push_ok = push & (~w_full | w_pop_ok);

  // Thresholds above DEPTH would make almost_full unreachable; clamp them.
  assign w_alto_clamped = (umbral_alto > CW'(DEPTH)) ? CW'(DEPTH) : umbral_alto;
  assign w_bajo_clamped = (umbral_bajo > CW'(DEPTH)) ? CW'(DEPTH) : umbral_bajo;

  // Storage array, intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // Pointers, occupancy, read data, error and thresholds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_data_out <= '0;
      r_valid    <= 1'b0;
      r_error    <= 1'b0;
      r_alto     <= CW'(DEPTH - 1);
      r_bajo     <= CW'(1);
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_pop_ok) begin
        r_data_out <= r_mem[r_rd_ptr];
        r_rd_ptr   <= r_rd_ptr + ADDR_W'(1);
      end
      r_valid <= w_pop_ok;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if ((push & ~w_push_ok) | (pop & ~w_pop_ok)) begin
        r_error <= 1'b1;
      end
      if (umbral_load) begin
        r_alto <= w_alto_clamped;
        r_bajo <= w_bajo_clamped;
      end
    end
  end

  assign data_out     = r_data_out;
  assign valid_out    = r_valid;
  assign count        = r_count;
  assign fifo_empty   = w_empty;
  assign fifo_full    = w_full;
  assign almost_full  = (r_count >= r_alto);
  assign almost_empty = (r_count <= r_bajo);
  assign fifo_error   = r_error;

endmodule

// File: tb/tb_fifo_umbral.sv
// tb_fifo_umbral: scenario tasks plus randomized traffic against a queue-based
// reference model of the threshold FIFO (DEPTH=8, DATA_W=6).
module tb_fifo_umbral;

  logic       clk = 1'b0;
  logic       reset;
  logic       push;
  logic [5:0] data_in;
  logic       pop;
  logic [5:0] data_out;
  logic       valid_out;
  logic       umbral_load;
  logic [3:0] umbral_alto;
  logic [3:0] umbral_bajo;
  logic [3:0] count;
  logic       fifo_empty;
  logic       fifo_full;
  logic       almost_full;
  logic       almost_empty;
  logic       fifo_error;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [5:0] m_q[$];
  logic [5:0] m_dout;
  logic       m_valid;
  logic       m_err;
  int         m_alto;
  int         m_bajo;

  fifo_umbral #(.DATA_W(6), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset), .push(push), .data_in(data_in), .pop(pop),
    .data_out(data_out), .valid_out(valid_out), .umbral_load(umbral_load),
    .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo), .count(count),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .almost_full(almost_full),
    .almost_empty(almost_empty), .fifo_error(fifo_error)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_q.delete();
    m_dout  = '0;
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_alto  = 7;
    m_bajo  = 1;
  endtask

  // Drive one edge's worth of inputs, advance the model, and return at the next negedge.
  task automatic step(input bit p, input logic [5:0] d, input bit po,
                      input bit ld, input int a, input int b);
    bit pop_ok, push_ok;
    push = p; data_in = d; pop = po;
    umbral_load = ld; umbral_alto = 4'(a); umbral_bajo = 4'(b);
    @(posedge clk);
    pop_ok  = po && (m_q.size() > 0);
    push_ok = p && ((m_q.size() < 8) || pop_ok);
    if ((p && !push_ok) || (po && !pop_ok)) m_err = 1'b1;
    if (pop_ok) begin
      m_dout  = m_q.pop_front();
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    if (push_ok) m_q.push_back(d);
    if (ld) begin
      m_alto = (a > 8) ? 8 : a;
      m_bajo = (b > 8) ? 8 : b;
    end
    #1;
    push = 1'b0; pop = 1'b0; umbral_load = 1'b0;
    @(negedge clk);
  endtask

  task automatic sync_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    push = 1'b0; pop = 1'b0; umbral_load = 1'b0; data_in = '0;
    umbral_alto = '0; umbral_bajo = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (count !== 4'd0 || fifo_empty !== 1'b1 || almost_empty !== 1'b1 ||
        fifo_full !== 1'b0 || almost_full !== 1'b0 || fifo_error !== 1'b0 ||
        data_out !== 6'd0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: cnt=%0d e=%b ae=%b f=%b af=%b err=%b dout=%0h v=%b, want 0 1 1 0 0 0 0 0",
               count, fifo_empty, almost_empty, fifo_full, almost_full, fifo_error, data_out, valid_out);
    end
    reset = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_fill();
    int n;
    step(0, 0, 0, 1, 6, 2);
    for (int i = 1; i <= 8; i++) begin
      step(1, 6'(i), 0, 0, 0, 0);
      n = m_q.size();
      checks++;
      if (count !== 4'(i) || almost_empty !== (i <= 2) || almost_full !== (i >= 6) ||
          fifo_full !== (i == 8) || fifo_error !== 1'b0 || n != i) begin
        errors++;
        $display("FAIL fill_%0d: cnt=%0d ae=%b af=%b f=%b err=%b", i, count, almost_empty,
                 almost_full, fifo_full, fifo_error);
      end
    end
    step(1, 6'h09, 0, 0, 0, 0);
    checks++;
    if (fifo_error !== 1'b1 || count !== 4'd8) begin
      errors++;
      $display("FAIL overflow: err=%b cnt=%0d want err=1 cnt=8", fifo_error, count);
    end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, 1, 0, 0, 0);
      checks++;
      if (data_out !== 6'(i) || valid_out !== 1'b1 || count !== 4'(8 - i)) begin
        errors++;
        $display("FAIL drain_%0d: dout=%0h v=%b cnt=%0d want dout=%0h v=1 cnt=%0d",
                 i, data_out, valid_out, count, i, 8 - i);
      end
    end
    checks++;
    if (fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL drain_empty: empty=%b want 1", fifo_empty);
    end
    step(0, 0, 1, 0, 0, 0);
    checks++;
    if (valid_out !== 1'b0 || data_out !== 6'h08 || fifo_error !== 1'b1 || count !== 4'd0) begin
      errors++;
      $display("FAIL underflow: v=%b dout=%0h err=%b cnt=%0d want 0 08 1 0",
               valid_out, data_out, fifo_error, count);
    end
  endtask

  task automatic test_empty_pushpop();
    sync_reset();
    step(1, 6'h15, 1, 0, 0, 0);
    checks++;
    if (count !== 4'd1 || fifo_error !== 1'b1 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL empty_pushpop: cnt=%0d err=%b v=%b want 1 1 0", count, fifo_error, valid_out);
    end
  endtask

  task automatic test_full_pushpop();
    logic [5:0] first;
    sync_reset();
    for (int i = 0; i < 8; i++) step(1, 6'($urandom_range(0, 63)), 0, 0, 0, 0);
    first = m_q[0];
    step(1, 6'h2A, 1, 0, 0, 0);
    checks++;
    if (count !== 4'd8 || data_out !== first || valid_out !== 1'b1 || fifo_error !== 1'b0) begin
      errors++;
      $display("FAIL full_pushpop: cnt=%0d dout=%0h v=%b err=%b want 8 %0h 1 0",
               count, data_out, valid_out, fifo_error, first);
    end
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0, 0);
    checks++;
    if (data_out !== 6'h2A || fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL full_pushpop_last: dout=%0h empty=%b want 2a 1", data_out, fifo_empty);
    end
  endtask

  task automatic test_wrap();
    logic [5:0] sent[$];
    logic [5:0] w;
    int bad;
    sync_reset();
    bad = 0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < ((r == 0) ? 5 : 8); i++) begin
        w = 6'($urandom_range(0, 63));
        sent.push_back(w);
        step(1, w, 0, 0, 0, 0);
      end
      for (int i = 0; i < ((r == 0) ? 5 : 8); i++) begin
        step(0, 0, 1, 0, 0, 0);
        w = sent.pop_front();
        if (data_out !== w || valid_out !== 1'b1) bad++;
      end
    end
    checks++;
    if (bad != 0 || fifo_error !== 1'b0 || fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL wrap_order: bad_words=%0d err=%b empty=%b want 0 0 1", bad, fifo_error, fifo_empty);
    end
  endtask

  task automatic test_async_reset();
    sync_reset();
    step(0, 0, 0, 1, 5, 3);
    step(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 6'(i + 3), 0, 0, 0, 0);
    checks++;
    if (count !== 4'd4 || fifo_error !== 1'b1) begin
      errors++;
      $display("FAIL pre_async: cnt=%0d err=%b want 4 1", count, fifo_error);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (count !== 4'd0 || fifo_empty !== 1'b1 || fifo_error !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: cnt=%0d empty=%b err=%b want 0 1 0", count, fifo_empty, fifo_error);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    // Thresholds back to 7/1: almost_empty through count 1, almost_full from count 7.
    for (int i = 1; i <= 7; i++) begin
      step(1, 6'(i), 0, 0, 0, 0);
      checks++;
      if (almost_empty !== (i <= 1) || almost_full !== (i >= 7)) begin
        errors++;
        $display("FAIL thr_default_%0d: ae=%b af=%b want %b %b", i, almost_empty, almost_full,
                 i <= 1, i >= 7);
      end
    end
  endtask

  task automatic test_clamp();
    sync_reset();
    step(0, 0, 0, 1, 15, 1);
    for (int i = 1; i <= 8; i++) begin
      step(1, 6'(i), 0, 0, 0, 0);
      checks++;
      if (almost_full !== (i == 8)) begin
        errors++;
        $display("FAIL clamp_%0d: af=%b want %b", i, almost_full, i == 8);
      end
    end
  endtask

  task automatic test_random();
    int n;
    bit p, po, ld;
    sync_reset();
    for (int c = 0; c < 400; c++) begin
      p  = ($urandom_range(0, 99) < 55);
      po = ($urandom_range(0, 99) < 45);
      ld = ($urandom_range(0, 99) < 8);
      step(p, 6'($urandom_range(0, 63)), po, ld, $urandom_range(0, 15), $urandom_range(0, 15));
      n = m_q.size();
      checks++;
      if (count !== 4'(n) || fifo_empty !== (n == 0) || fifo_full !== (n == 8) ||
          almost_full !== (n >= m_alto) || almost_empty !== (n <= m_bajo) ||
          fifo_error !== m_err || valid_out !== m_valid || data_out !== m_dout) begin
        errors++;
        $display("FAIL random_%0d: cnt=%0d/%0d e=%b f=%b af=%b ae=%b err=%b/%b v=%b/%b dout=%0h/%0h",
                 c, count, n, fifo_empty, fifo_full, almost_full, almost_empty,
                 fifo_error, m_err, valid_out, m_valid, data_out, m_dout);
      end
      if (($urandom_range(0, 99) < 2)) sync_reset();
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_empty_pushpop();
    test_full_pushpop();
    test_wrap();
    test_async_reset();
    test_clamp();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
